// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, access owner,
// and the saturating starvation-counter helper.
package klp32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt >= lim) ? lim : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if;

    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;

    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [3:0]  i_dm_be;
    logic        o_dm_gnt;
    logic        o_dm_rvalid;
    logic [31:0] o_dm_rdata;

    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    logic        o_mem_rdy;
    logic        o_bus_err;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_ack, i_mem_rdata,
        output o_mem_rdy, o_bus_err
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_ack, i_mem_rdata,
        input  o_mem_rdy, o_bus_err
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory, with
// fetch anti-starvation, access timeout and a pipeline stall signal.
module mem_port_arbiter
    import klp32_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] BUS_ERR_DATA   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_owner_t  r_owner;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_timeout_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_timed_out;

    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic        w_timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Grants are gated by reset so no handshake can complete while the block is held in reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_if_gnt      = 1'b0;
        w_dm_gnt      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (reset_n) begin
                    if (bus.i_dm_req && (!bus.i_if_req || (r_starve_cnt < STARVE_MAX)))
                        w_dm_gnt = 1'b1;
                    else if (bus.i_if_req)
                        w_if_gnt = 1'b1;
                end
                if (w_if_gnt || w_dm_gnt) w_state_nxt = BUSY;
            end
            BUSY: begin
                w_timeout_hit = !bus.i_mem_ack && (r_timeout_cnt == TO_LAST);
                if (bus.i_mem_ack || w_timeout_hit) w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
        end else if (w_dm_gnt) begin
            r_owner <= OWN_DM;
            r_addr  <= bus.i_dm_addr;
            r_wdata <= bus.i_dm_wdata;
            r_we    <= bus.i_dm_we;
            r_be    <= bus.i_dm_be;
        end else if (w_if_gnt) begin
            r_owner <= OWN_IF;
            r_addr  <= bus.i_if_addr;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= BE_WORD;
        end else if (r_state == RESP) begin
            r_owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_if_gnt)
                r_starve_cnt <= '0;
            else if (w_dm_gnt && bus.i_if_req)
                r_starve_cnt <= sat_inc4(r_starve_cnt, STARVE_MAX);
            r_timeout_cnt <= (r_state == BUSY) ? r_timeout_cnt + 8'd1 : 8'd0;
        end
    end

    // Stores never overwrite load data; an aborted access returns the error pattern to its owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_timed_out <= 1'b0;
        end else if (r_state == BUSY) begin
            if (bus.i_mem_ack) begin
                if (r_owner == OWN_IF)     r_if_rdata <= bus.i_mem_rdata;
                else if (!r_we)            r_dm_rdata <= bus.i_mem_rdata;
            end else if (w_timeout_hit) begin
                r_timed_out <= 1'b1;
                if (r_owner == OWN_IF)     r_if_rdata <= BUS_ERR_DATA;
                else                       r_dm_rdata <= BUS_ERR_DATA;
            end
        end else if (r_state == RESP) begin
            r_timed_out <= 1'b0;
        end
    end

    assign bus.o_if_gnt    = w_if_gnt;
    assign bus.o_dm_gnt    = w_dm_gnt;
    assign bus.o_if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
    assign bus.o_dm_rvalid = (r_state == RESP) && (r_owner == OWN_DM);
    assign bus.o_if_rdata  = r_if_rdata;
    assign bus.o_dm_rdata  = r_dm_rdata;
    assign bus.o_bus_err   = (r_state == RESP) && r_timed_out;

    assign bus.o_mem_req   = (r_state == BUSY);
    assign bus.o_mem_we    = r_we;
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_wdata = r_wdata;
    assign bus.o_mem_be    = r_be;

    // The DM response cycle itself does not stall, so the pipeline advances alongside o_dm_rvalid.
    assign bus.o_mem_rdy   = !reset_n ||
                             !((bus.i_dm_req && !w_dm_gnt) ||
                               ((r_owner == OWN_DM) && (r_state == BUSY)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, contention, stores,
// starvation, timeout and asynchronous reset mid-access.
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8),
        .BUS_ERR_DATA  (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int dm_n;
        int dm_gnts;
        logic exp_if;
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        bus.i_if_req = 1'b0;  bus.i_if_addr = '0;
        bus.i_dm_req = 1'b0;  bus.i_dm_we = 1'b0;  bus.i_dm_addr = '0;
        bus.i_dm_wdata = '0;  bus.i_dm_be = '0;
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;

        #2;
        chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        chk("rst_mem_we",  32'(bus.o_mem_we),  32'd0);
        chk("rst_mem_be",  32'(bus.o_mem_be),  32'd0);
        chk("rst_rvalid",  32'({bus.o_if_rvalid, bus.o_dm_rvalid}), 32'd0);
        chk("rst_if_rdata", bus.o_if_rdata, 32'd0);
        chk("rst_dm_rdata", bus.o_dm_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus.o_bus_err), 32'd0);
        chk("rst_mem_rdy", 32'(bus.o_mem_rdy), 32'd1);
        smp();
        reset_n = 1'b1;
        nxt();

        // Single fetch
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h100;
        smp();
        chk("t1_if_gnt", 32'(bus.o_if_gnt), 32'd1);
        chk("t1_rdy_c0", 32'(bus.o_mem_rdy), 32'd1);
        chk("t1_memreq_c0", 32'(bus.o_mem_req), 32'd0);
        nxt();
        bus.i_if_req = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0050_0093;
        smp();
        chk("t1_memreq_c1", 32'(bus.o_mem_req), 32'd1);
        chk("t1_addr", bus.o_mem_addr, 32'h100);
        chk("t1_we", 32'(bus.o_mem_we), 32'd0);
        chk("t1_be", 32'(bus.o_mem_be), 32'hF);
        chk("t1_rdy_c1", 32'(bus.o_mem_rdy), 32'd1);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t1_rvalid", 32'(bus.o_if_rvalid), 32'd1);
        chk("t1_rdata", bus.o_if_rdata, 32'h0050_0093);
        chk("t1_memreq_c2", 32'(bus.o_mem_req), 32'd0);
        chk("t1_rdy_c2", 32'(bus.o_mem_rdy), 32'd1);
        nxt();
        smp();
        chk("t1_rvalid_off", 32'(bus.o_if_rvalid), 32'd0);

        // Simultaneous IF and DM load: DM first
        nxt();
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h104;
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_addr = 32'h2000; bus.i_dm_be = 4'hF;
        smp();
        chk("t2_dm_gnt", 32'(bus.o_dm_gnt), 32'd1);
        chk("t2_if_gnt", 32'(bus.o_if_gnt), 32'd0);
        nxt();
        bus.i_dm_req = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hCAFE_F00D;
        smp();
        chk("t2_addr", bus.o_mem_addr, 32'h2000);
        chk("t2_rdy_busy", 32'(bus.o_mem_rdy), 32'd0);
        chk("t2_if_gnt_busy", 32'(bus.o_if_gnt), 32'd0);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t2_dm_rvalid", 32'(bus.o_dm_rvalid), 32'd1);
        chk("t2_dm_rdata", bus.o_dm_rdata, 32'hCAFE_F00D);
        chk("t2_rdy_resp", 32'(bus.o_mem_rdy), 32'd1);
        chk("t2_if_gnt_resp", 32'(bus.o_if_gnt), 32'd0);
        nxt();
        smp();
        chk("t2_if_gnt_idle", 32'(bus.o_if_gnt), 32'd1);
        nxt();
        bus.i_if_req = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0000_0013;
        smp();
        chk("t2_if_addr", bus.o_mem_addr, 32'h104);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t2_if_rvalid", 32'(bus.o_if_rvalid), 32'd1);
        nxt();

        // Partial store: fields pass through, load data untouched
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b1; bus.i_dm_addr = 32'h5000;
        bus.i_dm_wdata = 32'h1234_ABCD; bus.i_dm_be = 4'b0011;
        smp();
        chk("t6_gnt", 32'(bus.o_dm_gnt), 32'd1);
        nxt();
        bus.i_dm_req = 1'b0;
        smp();
        chk("t6_we", 32'(bus.o_mem_we), 32'd1);
        chk("t6_be", 32'(bus.o_mem_be), 32'h3);
        chk("t6_wdata", bus.o_mem_wdata, 32'h1234_ABCD);
        chk("t6_addr", bus.o_mem_addr, 32'h5000);
        nxt();
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF;
        smp();
        chk("t6_be_hold", 32'(bus.o_mem_be), 32'h3);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t6_rvalid", 32'(bus.o_dm_rvalid), 32'd1);
        chk("t6_rdata_kept", bus.o_dm_rdata, 32'hCAFE_F00D);
        nxt();

        // Starvation: IF held, six DM stores
        dm_n = 0; dm_gnts = 0;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h200;
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b1; bus.i_dm_be = 4'hF;
        bus.i_dm_addr = 32'h3000; bus.i_dm_wdata = 32'd0;
        for (int idx = 0; idx < 7; idx++) begin
            exp_if = (idx == 4);
            smp();
            chk($sformatf("t3_if_gnt%0d", idx), 32'(bus.o_if_gnt), 32'(exp_if));
            chk($sformatf("t3_dm_gnt%0d", idx), 32'(bus.o_dm_gnt), 32'(!exp_if));
            nxt();
            if (!exp_if) begin
                dm_gnts++;
                dm_n++;
                bus.i_dm_addr = 32'h3000 + 32'(4 * dm_n);
                bus.i_dm_wdata = 32'(dm_n);
                if (dm_gnts == 6) bus.i_dm_req = 1'b0;
            end
            bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1111_1111;
            smp();
            chk($sformatf("t3_addr%0d", idx), bus.o_mem_addr,
                exp_if ? 32'h200 : 32'h3000 + 32'(4 * (dm_n - 1)));
            chk($sformatf("t3_rdy_busy%0d", idx), 32'(bus.o_mem_rdy), 32'd0);
            nxt();
            bus.i_mem_ack = 1'b0;
            smp();
            chk($sformatf("t3_rvalid%0d", idx),
                32'({bus.o_if_rvalid, bus.o_dm_rvalid}), exp_if ? 32'd2 : 32'd1);
            chk($sformatf("t3_resp_nognt%0d", idx),
                32'({bus.o_if_gnt, bus.o_dm_gnt}), 32'd0);
            chk($sformatf("t3_rdy_resp%0d", idx), 32'(bus.o_mem_rdy), (idx == 6) ? 32'd1 : 32'd0);
            nxt();
        end
        smp();
        chk("t3_if_final_gnt", 32'(bus.o_if_gnt), 32'd1);
        nxt();
        bus.i_if_req = 1'b0; bus.i_mem_ack = 1'b1;
        nxt();
        bus.i_mem_ack = 1'b0;
        nxt();

        // Timeout on a store
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b1; bus.i_dm_addr = 32'h4000;
        bus.i_dm_wdata = 32'h5555_AAAA; bus.i_dm_be = 4'hF;
        smp();
        chk("t4_gnt", 32'(bus.o_dm_gnt), 32'd1);
        for (int c = 0; c < 8; c++) begin
            nxt();
            bus.i_dm_req = 1'b0;
            smp();
            chk($sformatf("t4_memreq%0d", c), 32'(bus.o_mem_req), 32'd1);
            chk($sformatf("t4_noerr%0d", c), 32'(bus.o_bus_err), 32'd0);
        end
        nxt();
        smp();
        chk("t4_memreq_drop", 32'(bus.o_mem_req), 32'd0);
        chk("t4_bus_err", 32'(bus.o_bus_err), 32'd1);
        chk("t4_rvalid", 32'(bus.o_dm_rvalid), 32'd1);
        chk("t4_rdata_err", bus.o_dm_rdata, 32'h0000_0000);
        nxt();
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h7777_7777;
        smp();
        chk("t4_stray_err", 32'(bus.o_bus_err), 32'd0);
        chk("t4_stray_rvalid", 32'(bus.o_dm_rvalid), 32'd0);
        chk("t4_stray_memreq", 32'(bus.o_mem_req), 32'd0);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t4_stray_rdata", bus.o_dm_rdata, 32'h0000_0000);
        chk("t4_stray_rvalid2", 32'(bus.o_dm_rvalid), 32'd0);
        nxt();

        // Asynchronous reset in the second BUSY cycle of a load
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_addr = 32'h6000;
        smp();
        chk("t5_gnt", 32'(bus.o_dm_gnt), 32'd1);
        nxt();
        bus.i_dm_req = 1'b0;
        nxt();
        smp();
        chk("t5_busy2_req", 32'(bus.o_mem_req), 32'd1);
        chk("t5_busy2_rdy", 32'(bus.o_mem_rdy), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_req", 32'(bus.o_mem_req), 32'd0);
        chk("t5_async_rdy", 32'(bus.o_mem_rdy), 32'd1);
        @(posedge clk);
        smp();
        reset_n = 1'b1;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h9999_9999;
        smp();
        chk("t5_no_rvalid", 32'(bus.o_dm_rvalid), 32'd0);
        chk("t5_no_req", 32'(bus.o_mem_req), 32'd0);
        nxt();
        bus.i_mem_ack = 1'b0;
        bus.i_dm_req = 1'b1; bus.i_dm_addr = 32'h6004;
        smp();
        chk("t5_regnt", 32'(bus.o_dm_gnt), 32'd1);
        chk("t5_rdata_clr", bus.o_dm_rdata, 32'd0);
        nxt();
        bus.i_dm_req = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0BAD_F00D;
        smp();
        chk("t5_addr", bus.o_mem_addr, 32'h6004);
        nxt();
        bus.i_mem_ack = 1'b0;
        smp();
        chk("t5_rvalid", 32'(bus.o_dm_rvalid), 32'd1);
        chk("t5_rdata", bus.o_dm_rdata, 32'h0BAD_F00D);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
